load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  MEM-stage initiator for the word-wide data memory: accepts byte/half/word load and store requests
//  from the pipeline and drives the memory's WE/address/write-data.
//  Returns aligned, sign/zero-extended load data.
//  Sub-word stores use a read-modify-write sequence, because the memory writes whole words only.
//  Sits between EX/MEM pipeline register and data memory; req_ready low stalls the pipeline.
// PARAMETERS
//  width  32   data word width (bits)
//  depth  256  memory depth in words; legal byte addresses 0 .. depth*4-1
//  addr   32   byte-address width of requests and of mem_addr
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  req_valid  in   1      request present
//  req_ready  out  1      unit can accept; transfer when req_valid && req_ready
//  req_wr     in   1      1 = store, 0 = load
//  req_size   in   2      00 byte, 01 half, 10 word, 11 illegal
//  req_uns    in   1      load zero-extends when 1 (ignored for stores and for word size)
//  req_addr   in   addr   byte address
//  req_wdata  in   width  store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid  out  1      one-cycle pulse: request complete
//  rsp_rdata  out  width  extended load data (0 for stores/errors)
//  rsp_err    out  1      misaligned, out-of-range or illegal size; no memory write occurred
//  mem_we     out  1      memory write enable
//  mem_addr   out  addr   word index = byte address >> 2
//  mem_wdata  out  width  full word to memory
//  mem_rdata  in   width  combinational read data of word at mem_addr
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_we=0; mem_addr=0;
//   mem_wdata=0. mem_we forced 0 in any cycle rst=1, so reset mid-RMW aborts with no write.
//   The pending response is dropped.
//  Byte lanes little-endian: lane k = bits [8k+7:8k], selected by req_addr[1:0].
//  Error check at accept: half needs addr[0]=0; word needs addr[1:0]=0; addr >= depth*4 is out of range;
//   size 11 is illegal. Any error -> no memory access; rsp_valid+rsp_err next cycle.
//  States:
//   IDLE:  req_ready=1; mem_addr = req_addr>>2 (combinational).
//          Load accepted: capture mem_rdata, extend lane into rsp_rdata; rsp_valid next cycle (latency 1).
//          SW accepted: mem_we=1, mem_wdata=req_wdata this cycle; rsp_valid next cycle (latency 1).
//          SB/SH accepted: latch addr/size/data -> RMW_RD.
//          Back-to-back accepts allowed; rsp_valid may coincide with the next accept.
//   RMW_RD: req_ready=0; mem_addr=latched; register mem_rdata into old_word -> RMW_WR.
//   RMW_WR: req_ready=0; mem_we=1; mem_wdata=old_word with target lane(s) replaced -> IDLE;
//          rsp_valid the following cycle. SB/SH total latency 3, stall 2 cycles.
//  Extension: LB/LH sign-extend bit 7/15 of selected lane; LBU/LHU zero-extend; LW passes word.
//  rsp_valid is held high for exactly one cycle; rsp_rdata/rsp_err hold until the next response.
//  req_* ignored when req_ready=0; the unit does not wait on rsp consumption (no back-pressure).
// STRUCTURE
//  Shared package (lsu_pkg): SIZE_BYTE/HALF/WORD encodings; state encoding IDLE/RMW_RD/RMW_WR;
//   byte-lane index width.
//  One sub-module: lsu_lane_align. Purely combinational; shared by load path and RMW path.
//   - Load extract: word + offset + size + uns -> extended data.
//   - Store merge: old word + offset + size + data -> merged word.
//  Top level holds the FSM, latches and response registers.
// TESTING
//  Reset mid-RMW: SB to 0x10, then rst in RMW_WR cycle -> mem_we=0, word 4 unchanged, no rsp, req_ready=1.
//  SW 0xDEADBEEF @0x8, then LW @0x8 -> mem_we pulse at word 2, rsp_rdata=0xDEADBEEF one cycle after accept.
//  Word 2=0xDEADBEEF: LB @0x9 -> 0xFFFFFFBE; LBU @0x9 -> 0x000000BE; LH @0xA -> 0xFFFFDEAD;
//   LHU @0xA -> 0x0000DEAD.
//  Word 2=0xDEADBEEF, SB 0x11 @0xB -> req_ready low 2 cycles, word 2 becomes 0x11ADBEEF, rsp 3 cycles after accept.
//   Then SH 0x2233 @0x8 -> 0x11AD2233.
//  Errors, each rsp_err=1 with no mem_we:
//   - LW @0x6 (misaligned); SH @0x3 (misaligned).
//   - LW @0x400 with depth=256 (out of range); size 11 (illegal).
//  Back-to-back LW @0x0, LW @0x4, then SW @0x3FC -> three accepts in consecutive cycles.
//   Responses arrive in consecutive cycles in order; last word index 255 written.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM
// state encoding, byte-lane geometry and the alignment rule used at accept.
package lsu_pkg;

    // Request size encodings (req_size_i)
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    // Byte-lane index width (4 lanes per word)
    localparam int LANE_W = 2;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RMW_RD = 2'd1;
    localparam logic [1:0] ST_RMW_WR = 2'd2;

    // Which lane(s) of a word an access touches
    typedef struct packed {
        logic [1:0]        size;
        logic [LANE_W-1:0] off;
    } lane_sel_t;

    // Halves must sit on even byte offsets, words on lane 0.
    function automatic logic size_misaligned(input logic [1:0] size,
                                             input logic [LANE_W-1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != '0);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering, shared by the load path and the
// read-modify-write store path.
//   ld_word_i  : word read from memory
//   ld_sel_i   : size/offset of the load
//   ld_uns_i   : zero-extend sub-word loads when set
//   ld_data_o  : right-justified, extended load data
//   st_old_i   : current memory word for a sub-word store
//   st_sel_i   : size/offset of the store
//   st_data_i  : right-justified store data
//   st_word_o  : old word with the target lane(s) replaced
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] ld_word_i,
    input  lane_sel_t        ld_sel_i,
    input  logic             ld_uns_i,
    output logic [WIDTH-1:0] ld_data_o,
    input  logic [WIDTH-1:0] st_old_i,
    input  lane_sel_t        st_sel_i,
    input  logic [WIDTH-1:0] st_data_i,
    output logic [WIDTH-1:0] st_word_o
);

    logic [WIDTH-1:0] ld_shifted;
    logic [WIDTH-1:0] st_mask;
    logic [4:0]       ld_sh;
    logic [4:0]       st_sh;

    assign ld_sh = {ld_sel_i.off, 3'b000};
    assign st_sh = {st_sel_i.off, 3'b000};

    // Load extract: bring the selected lane down to bit 0, then extend.
    always_comb begin
        ld_shifted = ld_word_i >> ld_sh;
        ld_data_o  = ld_word_i;
        case (ld_sel_i.size)
            SIZE_BYTE: ld_data_o = {{(WIDTH-8){~ld_uns_i & ld_shifted[7]}},
                                    ld_shifted[7:0]};
            SIZE_HALF: ld_data_o = {{(WIDTH-16){~ld_uns_i & ld_shifted[15]}},
                                    ld_shifted[15:0]};
            default:   ld_data_o = ld_word_i;
        endcase
    end

    // Store merge: clear the target lanes of the old word, OR in new data.
    always_comb begin
        case (st_sel_i.size)
            SIZE_BYTE: st_mask = WIDTH'(8'hFF);
            SIZE_HALF: st_mask = WIDTH'(16'hFFFF);
            default:   st_mask = '1;
        endcase
        st_word_o = (st_old_i & ~(st_mask << st_sh))
                  | ((st_data_i & st_mask) << st_sh);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for a word-wide data memory. Loads and word
// stores complete in one cycle; byte/half stores run a two-cycle
// read-modify-write because the memory only writes whole words.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   req_*_i / req_ready_o: request handshake (transfer on valid && ready)
//   rsp_valid_o          : one-cycle completion pulse
//   rsp_rdata_o/rsp_err_o: load data / error flag, held until next response
//   mem_we_o/addr/wdata  : memory write port, mem_addr_o is a word index
//   mem_rdata_i          : combinational read data of word at mem_addr_o
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_uns_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [WIDTH-1:0]  req_wdata_i,
    output logic              rsp_valid_o,
    output logic [WIDTH-1:0]  rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    input  logic [WIDTH-1:0]  mem_rdata_i
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    lane_sel_t         lat_sel_q, lat_sel_d;
    logic [WIDTH-1:0]  lat_data_q, lat_data_d;
    logic [WIDTH-1:0]  old_q, old_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic              req_err;
    lane_sel_t         req_sel;
    logic [WIDTH-1:0]  ld_ext;
    logic [WIDTH-1:0]  st_merged;

    assign req_sel = '{size: req_size_i, off: req_addr_i[LANE_W-1:0]};
    assign accept  = req_valid_i & req_ready_o;
    assign req_err = (req_size_i == SIZE_ILL)
                   | size_misaligned(req_size_i, req_addr_i[LANE_W-1:0])
                   | (req_addr_i >= ADDR_LIMIT);

    // Load side sees the live request (IDLE only); merge side sees the
    // latched store (RMW_WR only), so one instance serves both.
    lsu_lane_align #(.WIDTH(WIDTH)) u_align (
        .ld_word_i (mem_rdata_i),
        .ld_sel_i  (req_sel),
        .ld_uns_i  (req_uns_i),
        .ld_data_o (ld_ext),
        .st_old_i  (old_q),
        .st_sel_i  (lat_sel_q),
        .st_data_i (lat_data_q),
        .st_word_o (st_merged)
    );

    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_sel_d   = lat_sel_q;
        lat_data_d  = lat_data_q;
        old_d       = old_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = lat_addr_q >> 2;
        mem_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                mem_addr_o  = req_addr_i >> 2;
                if (accept) begin
                    if (req_err) begin
                        // No memory access at all on a bad request.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (!req_wr_i) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = ld_ext;
                    end else if (req_size_i == SIZE_WORD) begin
                        mem_we_o    = 1'b1;
                        mem_wdata_o = req_wdata_i;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                    end else begin
                        lat_addr_d = req_addr_i;
                        lat_sel_d  = req_sel;
                        lat_data_d = req_wdata_i;
                        state_d    = ST_RMW_RD;
                    end
                end
            end
            ST_RMW_RD: begin
                old_d   = mem_rdata_i;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_we_o    = 1'b1;
                mem_wdata_o = st_merged;
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // A reset landing in RMW_WR must not let the half-done write through.
        if (rst_i) begin
            req_ready_o = 1'b1;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            lat_addr_q  <= '0;
            lat_sel_q   <= '0;
            lat_data_q  <= '0;
            old_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_sel_q   <= lat_sel_d;
            lat_data_q  <= lat_data_d;
            old_q       <= old_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
